serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor.
- Reuses one full-adder cell and a carry flip-flop to add or subtract two W-bit operands, LSB first, one bit per clock.
- Sits beside the combinational adder library as the area-cheap arithmetic unit for datapaths that can tolerate W-cycle latency.
- Adds what the combinational cell lacks: operand width parameter, subtract mode, signed-overflow flag and a start/busy/done handshake.

Parameters:
- W, 8, operand/result width in bits; legal range 2..32.
- CW, 5, width of the internal bit counter; must satisfy 2**CW > W.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); sampled with start.
- cin  input  1  carry-in for add mode; sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while state = RUN.
- done  output  1  one-cycle pulse: result valid.
- sum  output  W  result; held until next accepted start.
- cout  output  1  carry out of the MSB (sub mode: 1 = no borrow).
- ovf  output  1  signed overflow (two's complement).

Behaviour:
- Reset (rst_n low, asynchronous) clears everything: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry FF=0, shift registers=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states:
  - IDLE: start=1 -> load, go to RUN.
  - RUN: counter==W-1 at the clock edge -> DONE, else stay in RUN.
  - DONE: start=1 -> load, go to RUN (back-to-back supported); else go to IDLE.
- Load (edge k):
  - A_sr<=a.
  - B_sr<= sub ? ~b : b.
  - carry<= sub ? 1 : cin.
  - counter<=0.
  - sum register is not cleared on load; its bits are overwritten by the shift.
- RUN, each edge:
  - Full adder computes s = A_sr[0]^B_sr[0]^carry, c = majority of the same three bits.
  - A_sr and B_sr shift right by 1.
  - s shifts into sum MSB (sum shifts right).
  - carry<=c; counter++.
- Final RUN edge (counter==W-1, edge k+W):
  - cout<=c.
  - ovf<= c ^ carry, where carry here is the carry into the MSB.
  - state<=DONE.
- Latency: done=1 in the cycle after edge k+W, i.e. W cycles after the start-sampling edge. Throughput is one result per W+1 cycles.
- start while busy=1 is ignored; operands and mode are not re-sampled.
- Outputs sum/cout/ovf are stable from DONE until the next load edge, and remain unchanged in IDLE.
- During RUN, sum holds partial shift contents and is not valid; consumers qualify sum with done.
- Arithmetic:
  - Add result = (a+b+cin) mod 2**W, cout = bit W of that sum.
  - Sub result = (a-b) mod 2**W, cout = (a>=b unsigned).
  - ovf uses signed interpretation in both modes.
- Boundary cases:
  - W-1 counter wrap is exact; the counter never exceeds W-1.
  - Simultaneous start and DONE exit: the load wins and done is still high for that cycle.

Decomposition:
- Shared package, constant/typedefs: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and the mode encodings ADD=1'b0, SUB=1'b1.
- One natural sub-module: the existing single-bit fulladder cell. It is instantiated once as the bit-slice compute element; its carry output registers into the carry FF.
- FSM, counter and shift registers stay in serial_addsub.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0 immediately, without waiting for a clock edge; no subsequent done pulse.
- Add (W=8): a=8'h3C, b=8'h47, cin=1, sub=0 -> done exactly 8 cycles after start edge; sum=8'h84, cout=0, ovf=1.
- Sub with borrow (W=8): a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0, ovf=0.
- Wrap/carry (W=8): a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0.
- Handshake: pulse start during RUN with different operands -> ignored, result matches the first operands. Assert start in the DONE cycle with a=1, b=2 -> second done 8 cycles later, sum=8'h03.
- Parameter sweep: W=2, 4, 16, 32 with 200 random operand/mode vectors each -> sum/cout/ovf match a reference model; done latency equals W every time.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state
// encoding and operation mode encoding.
package serial_addsub_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operation mode carried on the sub input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fulladder.sv
// Single-bit full adder cell, used as the one compute slice of the
// serial adder/subtractor.
module serial_addsub_fulladder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the 3-input parity, carry is the 3-input majority
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop
// processes W-bit operands LSB first, one bit per clock.
//
// Handshake: start is sampled only in IDLE or DONE; the edge that samples
// it loads a/b/sub/cin and enters RUN (busy=1). start while busy is ignored.
// done is high for exactly the one cycle spent in DONE, W cycles after the
// loading edge; sum/cout/ovf are valid while done=1 and hold until the next
// load. A start seen in the DONE cycle reloads immediately (done stays high
// for that cycle).
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [1:0]   state_dbg
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic          carry;
  logic          fa_s;
  logic          fa_c;
  logic          load;
  logic          last_bit;

  // The single compute slice: current LSBs plus the registered carry
  serial_addsub_fulladder u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // Decode load and final-bit conditions and the status outputs
  always_comb begin
    load      = start && ((state == ST_IDLE) || (state == ST_DONE));
    last_bit  = (state == ST_RUN) && (cnt == LAST);
    busy      = (state == ST_RUN);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

  // FSM: IDLE/DONE -> RUN on load, RUN -> DONE after the MSB, DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (load) state <= ST_RUN;
        ST_RUN:  if (last_bit) state <= ST_DONE;
        ST_DONE: state <= load ? ST_RUN : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bit counter: cleared on load, returns to zero after the MSB so it
  // never exceeds W-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (state == ST_RUN) begin
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

  // Operand shift registers and carry flop; subtract is a + ~b + 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= (sub == MODE_SUB) ? ~b : b;
      carry <= (sub == MODE_SUB) ? 1'b1 : cin;
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_c;
    end
  end

  // Result: sum bits shift in at the MSB; flags captured on the MSB edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == ST_RUN) begin
      sum <= {fa_s, sum[W-1:1]};
      if (last_bit) begin
        cout <= fa_c;
        ovf  <= fa_c ^ carry;
      end
    end
  end

endmodule
